// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with majority vote and FWFT receive FIFO
module uart_rx_cfg #(
    parameter logic [27:0] CLOCK_FREQ  = 28'd50000000,
    parameter logic [23:0] BAUD_RATE   = 24'd4000000,
    parameter int          DATA_BITS   = 8,
    parameter int          PARITY_MODE = 0,
    parameter int          STOP_BITS   = 1,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                 uart_clock,
    input  logic                 uart_reset,
    input  logic                 uart_d_in,
    input  logic                 uart_ready,
    output logic [DATA_BITS-1:0] uart_d_out,
    output logic                 uart_valid,
    output logic                 uart_parity_err,
    output logic                 uart_frame_err,
    output logic                 uart_overrun,
    output logic                 uart_busy
);
    localparam int PULSE = int'(CLOCK_FREQ / BAUD_RATE);
    localparam int HALF  = PULSE / 2;
    localparam int CW    = $clog2(PULSE);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNW   = AW + 1;
    localparam int WW    = DATA_BITS + 2;

    localparam logic [CW-1:0]  CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0]  CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0]  CNT_VOTE = CW'(HALF + 1);
    localparam logic [CW-1:0]  CNT_END  = CW'(PULSE - 1);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [CNW-1:0] DEPTH_C  = CNW'(FIFO_DEPTH);
    localparam logic           PAR_ODD  = (PARITY_MODE == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic sync1_q, rxs_q, rxs_prev_q;

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= uart_d_in;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 v0_q, v0_d, v1_q, v1_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 vote, at_vote, at_end, push;
    logic [WW-1:0]        push_word;

    // The third vote sample is the live value, so the bit resolves on the HALF+1 cycle.
    assign vote    = (v0_q & v1_q) | (v0_q & rxs_q) | (v1_q & rxs_q);
    assign at_vote = (cnt_q == CNT_VOTE);
    assign at_end  = (cnt_q == CNT_END);

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        bit_d     = bit_q;
        shift_d   = shift_q;
        v0_d      = v0_q;
        v1_d      = v1_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        push      = 1'b0;
        push_word = {ferr_q | ~vote, perr_q, shift_q};
        if (state_q != S_IDLE) begin
            cnt_d = at_end ? '0 : cnt_q + CW'(1);
            if (cnt_q == CNT_S0) v0_d = rxs_q;
            if (cnt_q == CNT_S1) v1_d = rxs_q;
        end
        case (state_q)
            S_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (at_vote && vote) begin
                    state_d = S_IDLE;
                end else if (at_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (at_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (at_end) begin
                    if (bit_q == LAST_DATA) begin
                        state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (at_vote) perr_d = ((^shift_q) ^ vote) != PAR_ODD;
                if (at_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (at_vote) begin
                    ferr_d = ferr_q | ~vote;
                    if (bit_q == LAST_STOP) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                if (at_end && state_d != S_IDLE) bit_d = bit_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            v0_q    <= 1'b1;
            v1_q    <= 1'b1;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    logic [WW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [CNW-1:0] count_q;
    logic           overrun_q, pop, push_ok;
    logic [WW-1:0]  head;

    assign uart_valid = (count_q != '0);
    assign pop        = uart_valid & uart_ready;
    assign push_ok    = push & ((count_q != DEPTH_C) | pop);

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop)     rd_q <= rd_q + AW'(1);
            count_q   <= count_q + CNW'(push_ok) - CNW'(pop);
            overrun_q <= push & ~push_ok;
        end
    end

    always_ff @(posedge uart_clock) begin
        if (push_ok) mem_q[wr_q] <= push_word;
    end

    assign head            = mem_q[rd_q];
    assign uart_d_out      = uart_valid ? head[DATA_BITS-1:0] : '0;
    assign uart_parity_err = uart_valid & head[DATA_BITS];
    assign uart_frame_err  = uart_valid & head[DATA_BITS+1];
    assign uart_overrun    = overrun_q;
    assign uart_busy       = (state_q != S_IDLE);
endmodule
